// File: rtl/ysyx_25020037_axi_sram_slave_if.sv
// AXI4 bundle between an LSU/IFU master port and the SRAM responder.
// One transaction in flight at a time; handshakes are plain valid/ready.
interface ysyx_25020037_axi_sram_slave_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;

   modport master (
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      output wvalid, wdata, wstrb, wlast, bready,
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  awready, wready, bvalid, bresp, bid,
      input  arready, rvalid, rdata, rresp, rlast, rid
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wvalid, wdata, wstrb, wlast, bready,
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output awready, wready, bvalid, bresp, bid,
      output arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/ysyx_25020037_axi_sram_slave.sv
// AXI4 responder over a word-addressed SRAM: one read or write burst at a time,
// read data after RD_LAT cycles, DECERR for beats outside the mapped window.
module ysyx_25020037_axi_sram_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          DEPTH     = 1024,
   parameter int          RD_LAT    = 2
) (
   input logic                           clk,
   input logic                           rst_n,
   ysyx_25020037_axi_sram_slave_if.slave bus
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [31:0] WIN      = 32'(4 * DEPTH);
   localparam logic [7:0]  LAT_INIT = 8'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, R_LAT, R_DATA, W_DATA, W_RESP} state_t;

   state_t      state, state_nx;
   logic [31:0] mem [DEPTH];
   logic [31:0] addr, adv_base, addr_nx, rd_addr, rd_off, wr_addr, wr_off;
   logic [1:0]  burst, adv_burst;
   logic [3:0]  id;
   logic [7:0]  len, cnt, lat;
   logic        err, arready_q, rresp_err, rlast_q;
   logic [31:0] rdata_q;
   logic        ar_hs, aw_hs, w_hs, r_hs, rd_in, wr_in;
   logic        unused_size;

   assign unused_size = ^{bus.awsize, bus.arsize};

   // arready_q is low for the first cycle after reset, which also blocks the AW+W path then.
   assign ar_hs = (state == IDLE) && arready_q && bus.arvalid;
   assign aw_hs = (state == IDLE) && arready_q && bus.awvalid && bus.wvalid && !bus.arvalid;
   assign w_hs  = (state == W_DATA) && bus.wvalid;
   assign r_hs  = (state == R_DATA) && bus.rready;

   assign adv_base  = (state == IDLE) ? bus.awaddr : addr;
   assign adv_burst = (state == IDLE) ? bus.awburst : burst;
   assign addr_nx   = (adv_burst == 2'b00) ? adv_base : adv_base + 32'd4;

   // In R_DATA the word fetched is the one for the beat after the current handshake.
   assign rd_addr = (state == R_DATA) ? addr_nx : addr;
   assign wr_addr = (state == IDLE) ? bus.awaddr : addr;
   assign rd_off  = rd_addr - BASE_ADDR;
   assign wr_off  = wr_addr - BASE_ADDR;
   assign rd_in   = rd_off < WIN;
   assign wr_in   = wr_off < WIN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (ar_hs)      state_nx = R_LAT;
            else if (aw_hs) state_nx = (bus.wlast || bus.awlen == 8'd0) ? W_RESP : W_DATA;
         end
         R_LAT:   if (lat == 8'd0) state_nx = R_DATA;
         R_DATA:  if (r_hs && cnt == len) state_nx = IDLE;
         W_DATA:  if (w_hs && (cnt == len || bus.wlast)) state_nx = W_RESP;
         W_RESP:  if (bus.bready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.arready = arready_q;
      bus.awready = aw_hs;
      bus.wready  = aw_hs || (state == W_DATA);
      bus.rvalid  = (state == R_DATA);
      bus.rdata   = rdata_q;
      bus.rresp   = {2{rresp_err}};
      bus.rlast   = rlast_q;
      bus.rid     = id;
      bus.bvalid  = (state == W_RESP);
      bus.bresp   = {2{err && (state == W_RESP)}};
      bus.bid     = id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arready_q <= 1'b0;
         addr      <= '0;
         burst     <= '0;
         id        <= '0;
         len       <= '0;
         cnt       <= '0;
         lat       <= '0;
         err       <= 1'b0;
         rdata_q   <= '0;
         rresp_err <= 1'b0;
         rlast_q   <= 1'b0;
      end else begin
         arready_q <= (state_nx == IDLE);
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  id    <= bus.arid;
                  addr  <= bus.araddr;
                  len   <= bus.arlen;
                  burst <= bus.arburst;
                  cnt   <= 8'd0;
                  lat   <= LAT_INIT;
               end else if (aw_hs) begin
                  id    <= bus.awid;
                  addr  <= addr_nx;
                  len   <= bus.awlen;
                  burst <= bus.awburst;
                  cnt   <= 8'd1;
                  err   <= !wr_in;
               end
            end
            R_LAT: begin
               lat <= lat - 8'd1;
               if (lat == 8'd0) begin
                  rdata_q   <= rd_in ? mem[rd_off[AW+1:2]] : 32'd0;
                  rresp_err <= !rd_in;
                  rlast_q   <= (len == 8'd0);
               end
            end
            R_DATA: begin
               if (r_hs && cnt != len) begin
                  addr      <= addr_nx;
                  cnt       <= cnt + 8'd1;
                  rdata_q   <= rd_in ? mem[rd_off[AW+1:2]] : 32'd0;
                  rresp_err <= !rd_in;
                  rlast_q   <= (cnt + 8'd1 == len);
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  addr <= addr_nx;
                  cnt  <= cnt + 8'd1;
                  err  <= err | !wr_in;
               end
            end
            W_RESP:  if (bus.bready) err <= 1'b0;
            default: ;
         endcase
      end
   end

   // SRAM array is deliberately not reset.
   always_ff @(posedge clk) begin
      if ((aw_hs || w_hs) && wr_in) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) mem[wr_off[AW+1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ysyx_25020037_axi_sram_slave.sv
// Randomised AXI traffic against a word-array model of the SRAM window.
module tb_ysyx_25020037_axi_sram_slave;
   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          DEPTH  = 1024;
   localparam int          RD_LAT = 2;

   logic        clk;
   logic        rst_n;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];

   ysyx_25020037_axi_sram_slave_if bus ();

   ysyx_25020037_axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   function automatic bit in_win(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2) % DEPTH;
   endfunction

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] bst, input int i);
      return (bst == 2'b00) ? a : a + 32'(4 * i);
   endfunction

   task automatic clear_inputs;
      bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 3'd2; bus.awburst = 0;
      bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
      bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 3'd2; bus.arburst = 0;
      bus.rready = 0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] bst, input bit gaps);
      bit err;
      int n;
      logic [31:0] ba;
      err = 0;
      bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awburst = bst; bus.awvalid = 1;
      bus.wdata = wd[0]; bus.wstrb = ws[0]; bus.wlast = (len == 8'd0); bus.wvalid = 1;
      for (int i = 0; i <= int'(len); i++) begin
         if (i > 0) begin
            if (gaps) begin
               repeat ($urandom % 3) begin
                  bus.wvalid = 0;
                  @(posedge clk); #1;
               end
            end
            bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == int'(len)); bus.wvalid = 1;
         end
         #1;
         n = 0;
         while (((i == 0) ? bus.awready : bus.wready) !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         tests++;
         if (n >= 50) begin
            fails++;
            $display("FAIL wr_accept beat%0d @%h: ready never rose within 50 cycles (want 1)", i, a);
            clear_inputs();
            return;
         end
         @(posedge clk); #1;
         bus.awvalid = 0;
         ba = beat_addr(a, bst, i);
         if (in_win(ba)) begin
            for (int b = 0; b < 4; b++)
               if (ws[i][b]) model[widx(ba)][8*b +: 8] = wd[i][8*b +: 8];
         end else begin
            err = 1;
         end
      end
      bus.wvalid = 0; bus.wlast = 0;
      tests++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== (err ? 2'b11 : 2'b00) || bus.bid !== id)
         begin
            fails++;
            $display("FAIL wr_resp @%h: got bvalid=%b bresp=%b bid=%h, want 1 %b %h",
                     a, bus.bvalid, bus.bresp, bus.bid, err ? 2'b11 : 2'b00, id);
         end
      repeat ($urandom % 3) begin
         @(posedge clk); #1;
         tests++;
         if (bus.bvalid !== 1'b1) begin
            fails++;
            $display("FAIL wr_resp_hold @%h: bvalid=%b, want 1", a, bus.bvalid);
         end
      end
      bus.bready = 1;
      @(posedge clk); #1;
      bus.bready = 0;
      tests++;
      if (bus.bvalid !== 1'b0) begin
         fails++;
         $display("FAIL wr_resp_drop @%h: bvalid=%b, want 0", a, bus.bvalid);
      end
   endtask

   // mode 0: rready always high, 1: toggles 1/0, 2: random
   task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] bst, input int mode);
      int n, i, guard;
      bit rr, tgl;
      logic [31:0] ba, ed;
      logic [1:0] er;
      bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arburst = bst; bus.arvalid = 1; bus.rready = 0;
      #1;
      n = 0;
      while (bus.arready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (n >= 50) begin
         fails++;
         $display("FAIL rd_accept @%h: arready=%b after 50 cycles, want 1", a, bus.arready);
         clear_inputs();
         return;
      end
      @(posedge clk); #1;
      bus.arvalid = 0;
      for (int k = 0; k < RD_LAT; k++) begin
         tests++;
         if (bus.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rd_latency @%h: rvalid=%b %0d cycles after AR, want 0", a, bus.rvalid, k);
         end
         @(posedge clk); #1;
      end
      i = 0; guard = 0; tgl = 1;
      while (i <= int'(len) && guard < 1000) begin
         ba = beat_addr(a, bst, i);
         ed = in_win(ba) ? model[widx(ba)] : 32'd0;
         er = in_win(ba) ? 2'b00 : 2'b11;
         tests++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== ed || bus.rresp !== er ||
             bus.rlast !== (i == int'(len)) || bus.rid !== id) begin
            fails++;
            $display("FAIL rd_beat%0d @%h: got vld=%b data=%h resp=%b last=%b id=%h, want vld=1 data=%h resp=%b last=%b id=%h",
                     i, ba, bus.rvalid, bus.rdata, bus.rresp, bus.rlast, bus.rid, ed, er, i == int'(len), id);
            if (bus.rvalid !== 1'b1) break;
         end
         rr = (mode == 0) ? 1'b1 : (mode == 1) ? tgl : 1'($urandom % 2);
         bus.rready = rr;
         @(posedge clk); #1;
         tgl = !tgl;
         if (rr) i++;
         guard++;
      end
      bus.rready = 0;
      tests++;
      if (bus.rvalid !== 1'b0) begin
         fails++;
         $display("FAIL rd_end @%h: rvalid=%b after last beat, want 0", a, bus.rvalid);
      end
   endtask

   task automatic test_reset;
      clear_inputs();
      rst_n = 0;
      bus.awvalid = 1; bus.wvalid = 1; bus.wstrb = 4'hF; bus.wlast = 1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0) begin
         fails++;
         $display("FAIL reset_hs: ar/aw/w/r/b=%b, want 00000",
                  {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
      end
      tests++;
      if ({bus.rdata, bus.rresp, bus.bresp, bus.rid, bus.bid, bus.rlast} !== 45'd0) begin
         fails++;
         $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b rid=%h bid=%h rlast=%b, want all 0",
                  bus.rdata, bus.rresp, bus.bresp, bus.rid, bus.bid, bus.rlast);
      end
      clear_inputs();
      #2 rst_n = 1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.arready !== 1'b1 || bus.awready !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: arready=%b awready=%b, want 1 0", bus.arready, bus.awready);
      end
   endtask

   task automatic test_write_read;
      wd[0] = 32'hDEADBEEF; ws[0] = 4'b1111;
      do_write(32'h8000_0010, 4'h5, 8'd0, 2'b01, 0);
      do_read(32'h8000_0010, 4'h2, 8'd0, 2'b01, 0);
      wd[0] = 32'h0000AB00; ws[0] = 4'b0010;
      do_write(32'h8000_0010, 4'hA, 8'd0, 2'b01, 0);
      do_read(32'h8000_0010, 4'h3, 8'd0, 2'b01, 0);
   endtask

   task automatic test_preload;
      for (int g = 0; g < 4; g++) begin
         for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom; ws[i] = 4'hF;
         end
         do_write(BASE + 32'(64 * g), 4'($urandom), 8'd15, 2'b01, 1);
      end
      wd[0] = $urandom; ws[0] = 4'hF;
      do_write(BASE + 32'(4 * (DEPTH - 1)), 4'h1, 8'd0, 2'b01, 0);
   endtask

   task automatic test_incr_burst;
      do_read(BASE, 4'h7, 8'd3, 2'b01, 1);
   endtask

   task automatic test_fixed_burst;
      do_read(BASE + 32'd28, 4'h4, 8'd3, 2'b00, 2);
      wd[0] = $urandom; ws[0] = 4'b1111;
      wd[1] = $urandom; ws[1] = 4'b0011;
      wd[2] = $urandom; ws[2] = 4'b1000;
      do_write(BASE + 32'd36, 4'hC, 8'd2, 2'b00, 1);
      do_read(BASE + 32'd32, 4'hD, 8'd2, 2'b01, 0);
   endtask

   task automatic test_decerr;
      do_read(32'h1000_0000, 4'h8, 8'd0, 2'b01, 0);
      wd[0] = $urandom; ws[0] = 4'hF;
      do_write(32'h1000_0000, 4'h9, 8'd0, 2'b01, 0);
      do_read(BASE, 4'h1, 8'd0, 2'b01, 0);
      do_read(BASE + 32'(4 * DEPTH - 4), 4'h2, 8'd1, 2'b01, 0);
      wd[0] = $urandom; ws[0] = 4'hF;
      wd[1] = $urandom; ws[1] = 4'hF;
      do_write(BASE + 32'(4 * DEPTH - 4), 4'hB, 8'd1, 2'b01, 0);
      do_read(BASE + 32'(4 * DEPTH - 4), 4'h3, 8'd0, 2'b01, 0);
      do_read(BASE, 4'h4, 8'd0, 2'b01, 0);
      do_read(BASE - 32'd8, 4'h5, 8'd3, 2'b10, 2);
   endtask

   task automatic test_collision;
      wd[0] = $urandom; ws[0] = 4'hF;
      bus.awaddr = BASE + 32'd80; bus.awid = 4'h3; bus.awlen = 0; bus.awburst = 2'b01; bus.awvalid = 1;
      bus.wdata = wd[0]; bus.wstrb = ws[0]; bus.wlast = 1; bus.wvalid = 1;
      bus.araddr = BASE + 32'd80; bus.arid = 4'h9; bus.arlen = 0; bus.arburst = 2'b01; bus.arvalid = 1;
      #1;
      tests++;
      if (bus.awready !== 1'b0 || bus.arready !== 1'b1) begin
         fails++;
         $display("FAIL collision_prio: awready=%b arready=%b, want 0 1", bus.awready, bus.arready);
      end
      do_read(BASE + 32'd80, 4'h9, 8'd0, 2'b01, 0);
      do_write(BASE + 32'd80, 4'h3, 8'd0, 2'b01, 0);
      do_read(BASE + 32'd80, 4'hE, 8'd0, 2'b01, 0);
   endtask

   task automatic test_reset_mid;
      int n;
      bus.araddr = BASE; bus.arid = 4'h6; bus.arlen = 8'd7; bus.arburst = 2'b01; bus.arvalid = 1; bus.rready = 0;
      #1;
      n = 0;
      while (bus.arready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      bus.arvalid = 0;
      repeat (RD_LAT) @(posedge clk);
      #1;
      tests++;
      if (bus.rvalid !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_setup: rvalid=%b before reset, want 1", bus.rvalid);
      end
      bus.awaddr = BASE; bus.awlen = 0; bus.awburst = 2'b01; bus.awvalid = 1;
      bus.wdata = ~model[0]; bus.wstrb = 4'hF; bus.wlast = 1; bus.wvalid = 1;
      #2 rst_n = 0;
      #1;
      tests++;
      if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0 ||
          bus.rdata !== 32'd0 || bus.rlast !== 1'b0 || bus.rid !== 4'd0) begin
         fails++;
         $display("FAIL reset_mid: ar/aw/w/r/b=%b rdata=%h rlast=%b rid=%h, want 00000 0 0 0",
                  {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}, bus.rdata, bus.rlast, bus.rid);
      end
      @(posedge clk); #1;
      clear_inputs();
      #2 rst_n = 1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.arready !== 1'b1 || bus.awready !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_release: arready=%b awready=%b, want 1 0", bus.arready, bus.awready);
      end
      do_read(BASE, 4'h6, 8'd7, 2'b01, 2);
   endtask

   task automatic test_back_to_back;
      logic [31:0] a;
      logic [7:0] len;
      logic [1:0] bst;
      for (int t = 0; t < 40; t++) begin
         len = 8'($urandom % 8);
         bst = 2'($urandom % 3);
         if ($urandom % 8 == 0) a = BASE - 32'd16 + 32'(4 * ($urandom % 4));
         else                   a = BASE + 32'(4 * ($urandom % 56));
         if ($urandom % 2) begin
            for (int i = 0; i < 16; i++) begin
               wd[i] = $urandom; ws[i] = 4'($urandom);
            end
            do_write(a, 4'($urandom), len, bst, 1'($urandom % 2));
         end else begin
            do_read(a, 4'($urandom), len, bst, int'($urandom % 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_preload();
      test_incr_burst();
      test_fixed_burst();
      test_decerr();
      test_collision();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
